// File: rtl/crtc_pkg.sv
// Shared definitions for the CRT controller: register indices and the
// configuration bundle passed from the register file to the timing core.
package crtc_pkg;

  localparam logic [4:0] R_HTOTAL   = 5'd0;
  localparam logic [4:0] R_HDISP    = 5'd1;
  localparam logic [4:0] R_HSPOS    = 5'd2;
  localparam logic [4:0] R_WIDTHS   = 5'd3;
  localparam logic [4:0] R_VTOTAL   = 5'd4;
  localparam logic [4:0] R_VADJ     = 5'd5;
  localparam logic [4:0] R_VDISP    = 5'd6;
  localparam logic [4:0] R_VSPOS    = 5'd7;
  localparam logic [4:0] R_MODE     = 5'd8;
  localparam logic [4:0] R_MAXRA    = 5'd9;
  localparam logic [4:0] R_CURSTART = 5'd10;
  localparam logic [4:0] R_CUREND   = 5'd11;
  localparam logic [4:0] R_STARTHI  = 5'd12;
  localparam logic [4:0] R_STARTLO  = 5'd13;
  localparam logic [4:0] R_CURHI    = 5'd14;
  localparam logic [4:0] R_CURLO    = 5'd15;

  localparam int unsigned VSYNC_ZERO_LINES = 16;

  typedef struct packed {
    logic [7:0] htotal;
    logic [7:0] hdisp;
    logic [7:0] hspos;
    logic [3:0] vsync_w;
    logic [3:0] hsync_w;
    logic [6:0] vtotal;
    logic [4:0] vadj;
    logic [6:0] vdisp;
    logic [6:0] vspos;
    logic [4:0] maxra;
    logic [4:0] curstart;
    logic [4:0] curend;
    logic [5:0] start_hi;
    logic [7:0] start_lo;
    logic [5:0] cur_hi;
    logic [7:0] cur_lo;
  } crtc_cfg_t;

  localparam int CFG_W = $bits(crtc_cfg_t);

endpackage

// File: rtl/crtc_regs.sv
// CPU-facing register file: address latch, write decode of R0..R15 and the
// cursor-address readback mux.
module crtc_regs
  import crtc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cs,
  input  logic             i_rs,
  input  logic             i_we,
  input  logic [7:0]       i_di,
  output logic [7:0]       o_dout,
  output logic [CFG_W-1:0] o_cfg
);

  logic [4:0] r_addr;
  crtc_cfg_t  r_cfg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_cfg  <= '0;
    end else if (i_cs && i_we) begin
      if (!i_rs) begin
        r_addr <= i_di[4:0];
      end else begin
        // R8 and R16..R31 fall through to the default and are dropped.
        case (r_addr)
          R_HTOTAL:   r_cfg.htotal   <= i_di;
          R_HDISP:    r_cfg.hdisp    <= i_di;
          R_HSPOS:    r_cfg.hspos    <= i_di;
          R_WIDTHS: begin
            r_cfg.hsync_w <= i_di[3:0];
            r_cfg.vsync_w <= i_di[7:4];
          end
          R_VTOTAL:   r_cfg.vtotal   <= i_di[6:0];
          R_VADJ:     r_cfg.vadj     <= i_di[4:0];
          R_VDISP:    r_cfg.vdisp    <= i_di[6:0];
          R_VSPOS:    r_cfg.vspos    <= i_di[6:0];
          R_MAXRA:    r_cfg.maxra    <= i_di[4:0];
          R_CURSTART: r_cfg.curstart <= i_di[4:0];
          R_CUREND:   r_cfg.curend   <= i_di[4:0];
          R_STARTHI:  r_cfg.start_hi <= i_di[5:0];
          R_STARTLO:  r_cfg.start_lo <= i_di;
          R_CURHI:    r_cfg.cur_hi   <= i_di[5:0];
          R_CURLO:    r_cfg.cur_lo   <= i_di;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_dout = '0;
    if (i_rs) begin
      if (r_addr == R_CURHI) begin
        o_dout = {2'b00, r_cfg.cur_hi};
      end else if (r_addr == R_CURLO) begin
        o_dout = r_cfg.cur_lo;
      end
    end
  end

  assign o_cfg = r_cfg;

endmodule

// File: rtl/crtc.sv
// 6845-style CRT controller core: character/raster/row counters, video
// address generation and registered sync, display-enable and cursor outputs.
module crtc
  import crtc_pkg::*;
#(
  parameter int MA_W = 14,
  parameter int RA_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cce,
  input  logic            cs,
  input  logic            rs,
  input  logic            we,
  input  logic [7:0]      di,
  output logic [7:0]      dout,
  output logic            hSync,
  output logic            vSync,
  output logic            de,
  output logic            cursor,
  output logic [MA_W-1:0] ma,
  output logic [RA_W-1:0] ra
);

  logic [CFG_W-1:0] w_cfg_bits;
  crtc_cfg_t        w_cfg;

  crtc_regs u_regs (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_cs   (cs),
    .i_rs   (rs),
    .i_we   (we),
    .i_di   (di),
    .o_dout (dout),
    .o_cfg  (w_cfg_bits)
  );

  assign w_cfg = crtc_cfg_t'(w_cfg_bits);

  logic [7:0]      r_hc;
  logic [RA_W-1:0] r_ra;
  logic [6:0]      r_row;
  logic            r_adj;
  logic [MA_W-1:0] r_ma;
  logic [MA_W-1:0] r_line_start;
  logic [3:0]      r_hs_cnt;
  logic [4:0]      r_vs_cnt;
  logic            r_de;
  logic            r_hs;
  logic            r_vs;
  logic            r_cur;

  logic            w_eol;
  logic            w_ra_last;
  logic            w_adj_last;
  logic            w_row_end;
  logic            w_frame_end;
  logic            w_enter_adj;
  logic [MA_W-1:0] w_start;
  logic [MA_W-1:0] w_next_ls;
  logic            w_de;
  logic            w_cur;
  logic            w_hs_trig;
  logic [3:0]      w_hs_cur;
  logic            w_vs_trig;
  logic [4:0]      w_vs_len;
  logic [4:0]      w_vs_cur;

  assign w_eol       = (r_hc == w_cfg.htotal);
  assign w_ra_last   = (r_ra == RA_W'(w_cfg.maxra));
  assign w_adj_last  = (r_ra == RA_W'(w_cfg.vadj - 5'd1));
  assign w_row_end   = w_eol && !r_adj && w_ra_last;
  assign w_enter_adj = w_row_end && (r_row == w_cfg.vtotal) && (w_cfg.vadj != 5'd0);
  assign w_frame_end = w_eol && (r_adj ? w_adj_last :
                       (w_ra_last && (r_row == w_cfg.vtotal) && (w_cfg.vadj == 5'd0)));
  assign w_start     = MA_W'({w_cfg.start_hi, w_cfg.start_lo});
  assign w_next_ls   = r_line_start + MA_W'(w_cfg.hdisp);

  assign w_de  = (r_hc < w_cfg.hdisp) && (r_row < w_cfg.vdisp) && !r_adj;
  assign w_cur = w_de && (r_ma == MA_W'({w_cfg.cur_hi, w_cfg.cur_lo})) &&
                 (r_ra >= RA_W'(w_cfg.curstart)) && (r_ra <= RA_W'(w_cfg.curend));

  // Counters hold the number of sync units still to emit, including the current one.
  assign w_hs_trig = (r_hc == w_cfg.hspos) && (w_cfg.hsync_w != 4'd0);
  assign w_hs_cur  = w_hs_trig ? w_cfg.hsync_w : r_hs_cnt;
  assign w_vs_trig = (r_hc == 8'd0) && (r_row == w_cfg.vspos) && (r_ra == '0) && !r_adj &&
                     (r_vs_cnt == 5'd0);
  assign w_vs_len  = (w_cfg.vsync_w == 4'd0) ? 5'(VSYNC_ZERO_LINES) : {1'b0, w_cfg.vsync_w};
  assign w_vs_cur  = w_vs_trig ? w_vs_len : r_vs_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hc         <= '0;
      r_ra         <= '0;
      r_row        <= '0;
      r_adj        <= 1'b0;
      r_ma         <= '0;
      r_line_start <= '0;
      r_hs_cnt     <= '0;
      r_vs_cnt     <= '0;
      r_de         <= 1'b0;
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_cur        <= 1'b0;
    end else if (cce) begin
      r_de     <= w_de;
      r_cur    <= w_cur;
      r_hs     <= (w_hs_cur != 4'd0);
      r_hs_cnt <= (w_hs_cur != 4'd0) ? w_hs_cur - 4'd1 : 4'd0;
      r_vs     <= (w_vs_cur != 5'd0);
      r_vs_cnt <= (w_eol && (w_vs_cur != 5'd0)) ? w_vs_cur - 5'd1 : w_vs_cur;
      if (w_eol) begin
        r_hc <= '0;
        if (w_frame_end) begin
          r_row        <= '0;
          r_ra         <= '0;
          r_adj        <= 1'b0;
          r_line_start <= w_start;
          r_ma         <= w_start;
        end else if (w_row_end) begin
          r_ra         <= '0;
          r_line_start <= w_next_ls;
          r_ma         <= w_next_ls;
          if (w_enter_adj) begin
            r_adj <= 1'b1;
          end else begin
            r_row <= r_row + 7'd1;
          end
        end else begin
          r_ra <= r_ra + RA_W'(1);
          r_ma <= r_line_start;
        end
      end else begin
        r_hc <= r_hc + 8'd1;
        r_ma <= r_ma + MA_W'(1);
      end
    end
  end

  assign hSync  = r_hs;
  assign vSync  = r_vs;
  assign de     = r_de;
  assign cursor = r_cur;
  assign ma     = r_ma;
  assign ra     = r_ra;

endmodule

// File: tb/tb_crtc.sv
// Bench for crtc: frame-position reference model compared cycle by cycle,
// plus fixed expectations for line/frame geometry, sync widths and the CPU port.
module tb_crtc;

  logic        clock = 1'b0;
  logic        reset;
  logic        cce, cs, rs, we;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        hSync, vSync, de, cursor;
  logic [13:0] ma;
  logic [4:0]  ra;

  crtc #(
    .MA_W (14),
    .RA_W (5)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .cce    (cce),
    .cs     (cs),
    .rs     (rs),
    .we     (we),
    .di     (di),
    .dout   (dout),
    .hSync  (hSync),
    .vSync  (vSync),
    .de     (de),
    .cursor (cursor),
    .ma     (ma),
    .ra     (ra)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: programmed register values plus position within the frame.
  int mr[16];
  int m_s, m_k, m_h, m_base, hs_rem, vs_rem;
  logic e_de, e_hs, e_vs, e_cur;
  int e_ma, e_ra;

  function automatic int mask(input int a);
    case (a)
      4, 6, 7:       return 'h7f;
      5, 9, 10, 11:  return 'h1f;
      12, 14:        return 'h3f;
      default:       return 'hff;
    endcase
  endfunction

  function automatic void calc(input int s, input int k, output int row, output int r,
                               output int adj, output int m);
    int per, nrm, lrow;
    per = mr[9] + 1;
    nrm = (mr[4] + 1) * per;
    if (s < nrm) begin
      row = s / per; r = s % per; adj = 0; lrow = row;
    end else begin
      row = mr[4]; r = s - nrm; adj = 1; lrow = mr[4] + 1;
    end
    m = (m_base + lrow * mr[1] + k) % 16384;
  endfunction

  task automatic model_step();
    int row, r, adj, m, hw, vw, nrm;
    calc(m_s, m_k, row, r, adj, m);
    e_de  = (m_h < mr[1]) && (row < mr[6]) && (adj == 0);
    e_cur = e_de && (m == ((mr[14] << 8) | mr[15])) && (r >= mr[10]) && (r <= mr[11]);
    hw = mr[3] & 15;
    vw = mr[3] >> 4;
    if (vw == 0) vw = 16;
    if (m_h == mr[2] && hw != 0) hs_rem = hw;
    e_hs = (hs_rem != 0);
    if (hs_rem != 0) hs_rem--;
    if (m_h == 0 && row == mr[7] && r == 0 && adj == 0 && vs_rem == 0) vs_rem = vw;
    e_vs = (vs_rem != 0);
    if (m_h == mr[0] && vs_rem != 0) vs_rem--;
    if (m_h == mr[0]) begin
      m_h = 0; m_k = 0; m_s++;
      nrm = (mr[4] + 1) * (mr[9] + 1);
      if (m_s == nrm + mr[5]) begin
        m_s = 0;
        m_base = (mr[12] << 8) | mr[13];
      end
    end else begin
      m_h = (m_h + 1) & 255;
      m_k++;
    end
    calc(m_s, m_k, row, r, adj, m);
    e_ma = m;
    e_ra = r;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    cce = 1'b1;
    cyc();
    model_step();
    cce = 1'b0;
  endtask

  task automatic wr(input int a, input int d, input bit with_cce);
    cs = 1'b1; we = 1'b1; rs = 1'b0; di = a[7:0]; cce = 1'b0;
    cyc();
    rs = 1'b1; di = d[7:0]; cce = with_cce;
    cyc();
    if (with_cce) model_step();
    if (a < 16 && a != 8) mr[a] = d & mask(a);
    cs = 1'b0; we = 1'b0; rs = 1'b0; cce = 1'b0;
  endtask

  task automatic set_addr(input int a);
    cs = 1'b1; we = 1'b1; rs = 1'b0; di = a[7:0];
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cce = 1'b1; cs = 1'b1; rs = 1'b1; we = 1'b0; di = '0;
    for (int i = 0; i < 16; i++) mr[i] = 0;
    m_s = 0; m_k = 0; m_h = 0; m_base = 0; hs_rem = 0; vs_rem = 0;
    cyc();
    cyc();
    n_tests++;
    if ({de, hSync, vSync, cursor} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: de/hs/vs/cur=%b required 0000", {de, hSync, vSync, cursor});
    end
    n_tests++;
    if (ma !== 14'h0 || ra !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_addr: ma=%0h ra=%0h required 0/0", ma, ra);
    end
    n_tests++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: dout=%0h required 0", dout);
    end
    reset = 1'b0; cce = 1'b0; cs = 1'b0; rs = 1'b0;
    cyc();
  endtask

  task automatic test_program();
    wr(0, 9, 0);  wr(1, 6, 0);  wr(2, 7, 0);  wr(3, 'h22, 0);
    wr(4, 3, 0);  wr(5, 1, 0);  wr(6, 2, 0);  wr(7, 3, 0);
    wr(9, 1, 0);  wr(12, 0, 0); wr(13, 'h10, 0);
  endtask

  task automatic test_timing();
    int ls_ma[10] = '{'h10, 'h10, 'h16, 'h16, 'h1c, 'h1c, 'h22, 'h22, 'h28, 'h10};
    int ls_ra[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int de_n = 0, hs_n = 0, vs_n = 0, vs_first = 0, hs_first = 0;
    for (int f = 0; f < 2; f++) begin
      for (int c = 1; c <= 90; c++) begin
        step();
        n_tests++;
        if (ma !== 14'(e_ma) || ra !== 5'(e_ra)) begin
          n_fail++;
          $display("FAIL timing_addr f%0d c%0d: ma=%0h ra=%0d required ma=%0h ra=%0d",
                   f, c, ma, ra, e_ma, e_ra);
        end
        n_tests++;
        if (de !== e_de || hSync !== e_hs || vSync !== e_vs) begin
          n_fail++;
          $display("FAIL timing_sync f%0d c%0d: de/hs/vs=%b%b%b required %b%b%b",
                   f, c, de, hSync, vSync, e_de, e_hs, e_vs);
        end
        if (f == 1) begin
          de_n += int'(de); hs_n += int'(hSync); vs_n += int'(vSync);
          if (vSync && vs_first == 0) vs_first = c;
          if (hSync && hs_first == 0) hs_first = c;
          if (c % 10 == 0) begin
            n_tests++;
            if (ma !== 14'(ls_ma[c/10]) || ra !== 5'(ls_ra[c/10])) begin
              n_fail++;
              $display("FAIL line_start c%0d: ma=%0h ra=%0d required ma=%0h ra=%0d",
                       c, ma, ra, ls_ma[c/10], ls_ra[c/10]);
            end
          end
        end
      end
    end
    n_tests++;
    if (de_n != 24) begin n_fail++; $display("FAIL de_count: %0d required 24", de_n); end
    n_tests++;
    if (hs_n != 18 || hs_first != 8) begin
      n_fail++;
      $display("FAIL hsync_shape: count=%0d first=%0d required 18/8", hs_n, hs_first);
    end
    n_tests++;
    if (vs_n != 20 || vs_first != 61) begin
      n_fail++;
      $display("FAIL vsync_shape: count=%0d first=%0d required 20/61", vs_n, vs_first);
    end
  endtask

  task automatic test_vsync16();
    int run = 0, max_run = 0;
    logic hi_91 = 1'b0;
    wr(3, 'h02, 0);
    for (int c = 1; c <= 270; c++) begin
      step();
      n_tests++;
      if (vSync !== e_vs || hSync !== e_hs) begin
        n_fail++;
        $display("FAIL vsync16 c%0d: vs/hs=%b%b required %b%b", c, vSync, hSync, e_vs, e_hs);
      end
      run = vSync ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (c == 91) hi_91 = vSync;
    end
    n_tests++;
    if (max_run != 160 || hi_91 !== 1'b1) begin
      n_fail++;
      $display("FAIL vsync16_len: run=%0d at_wrap=%b required 160/1", max_run, hi_91);
    end
  endtask

  task automatic test_cursor();
    int pulses = 0, first = 0;
    wr(14, 'h00, 0); wr(15, 'h12, 0); wr(10, 1, 0); wr(11, 1, 0);
    set_addr(14); rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL read_r14: dout=%0h required 0", dout); end
    set_addr(15); rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h12) begin n_fail++; $display("FAIL read_r15: dout=%0h required 12", dout); end
    rs = 1'b0; #1;
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL read_rs0: dout=%0h required 0", dout); end
    for (int c = 1; c <= 90; c++) begin
      step();
      n_tests++;
      if (cursor !== e_cur || de !== e_de) begin
        n_fail++;
        $display("FAIL cursor c%0d: cur/de=%b%b required %b%b", c, cursor, de, e_cur, e_de);
      end
      if (cursor) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    n_tests++;
    if (pulses != 1 || first != 13) begin
      n_fail++;
      $display("FAIL cursor_pulse: count=%0d at=%0d required 1/13", pulses, first);
    end
  endtask

  task automatic test_bad_addr();
    wr(20, 'hff, 0);
    rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL bad_addr_dout: dout=%0h required 0", dout); end
    wr(8, 'hff, 0);
    set_addr(15); rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h12) begin n_fail++; $display("FAIL bad_addr_r15: dout=%0h required 12", dout); end
    set_addr(14); rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL bad_addr_r14: dout=%0h required 0", dout); end
    rs = 1'b0;
  endtask

  task automatic test_hwrap_and_reset();
    int de_hi = 0;
    for (int i = 0; i < 20 && m_h != 8; i++) step();
    n_tests++;
    if (m_h != 8) begin n_fail++; $display("FAIL hwrap_sync: hc=%0d required 8", m_h); end
    // Lower R0 on the same cycle as a cce: that edge still uses R0=9.
    wr(0, 4, 1);
    for (int c = 1; c <= 260; c++) begin
      step();
      n_tests++;
      if (ma !== 14'(e_ma) || ra !== 5'(e_ra) || de !== e_de || hSync !== e_hs) begin
        n_fail++;
        $display("FAIL hwrap c%0d: ma=%0h ra=%0d de=%b hs=%b required ma=%0h ra=%0d de=%b hs=%b",
                 c, ma, ra, de, hSync, e_ma, e_ra, e_de, e_hs);
      end
      if (c <= 247) de_hi += int'(de);
    end
    n_tests++;
    if (de_hi != 0) begin n_fail++; $display("FAIL hwrap_de: de high %0d times required 0", de_hi); end
    set_addr(15); rs = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({de, hSync, vSync, cursor} !== 4'b0000 || ma !== 14'h0 || ra !== 5'h0) begin
      n_fail++;
      $display("FAIL async_reset: flags=%b ma=%0h ra=%0h required 0", {de, hSync, vSync, cursor},
               ma, ra);
    end
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL async_reset_dout: dout=%0h required 0", dout); end
    cyc();
    reset = 1'b0;
    set_addr(15); rs = 1'b1; #1;
    n_tests++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_r15: dout=%0h required 0", dout); end
    rs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_timing();
    test_vsync16();
    test_cursor();
    test_bad_addr();
    test_hwrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crtc.md
Name: crtc

Overview:
- Simplified 6845-style CRT controller. It generates character-rate timing and video RAM addressing for the pixel serialiser (the video block), which consumes its hSync and de.
- The CPU programs it through a two-cycle address/data register port.
- Its ma and ra outputs drive the video RAM address mux.
- All timing advances on a character clock enable (cce), which pulses once per 8 pixel enables.

Parameters:
- MA_W, 14, width of the memory address output and start-address registers.
- RA_W, 5, width of the raster (scanline-in-row) counter.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cce  in  1  character clock enable; counters advance only when high.
- cs  in  1  CPU chip select.
- rs  in  1  0 = address register, 1 = data register.
- we  in  1  CPU write strobe, sampled when cs=1 (one-cycle pulse).
- di  in  8  CPU write data.
- dout  out  8  CPU read data (combinational).
- hSync  out  1  horizontal sync, active high.
- vSync  out  1  vertical sync, active high.
- de  out  1  display enable.
- cursor  out  1  cursor active at the current character.
- ma  out  MA_W  video memory address.
- ra  out  RA_W  raster address within the character row.

Behaviour:
- Reset (async): all registers, counters and outputs go to 0; dout = 0.
- CPU port:
  - cs&we&~rs: addr <= di[4:0].
  - cs&we&rs: write R[addr].
  - Implemented registers and their stored bits:
    - R0 htotal[7:0], R1 hdisp[7:0], R2 hspos[7:0].
    - R3 widths: [3:0] hsync chars, [7:4] vsync lines.
    - R4 vtotal[6:0], R5 vadj[4:0], R6 vdisp[6:0], R7 vspos[6:0].
    - R9 maxra[4:0], R10 curstart[4:0], R11 curend[4:0].
    - R12 start hi[5:0], R13 start lo[7:0], R14 cursor hi[5:0], R15 cursor lo[7:0].
  - Writes to R8 and R16..R31 are ignored.
  - dout = R14 or R15 when rs=1 and addr selects them; 0 otherwise.
  - A write in the same cycle as cce takes effect after that edge; that cce's comparisons use the old value.
- Horizontal, on each cce:
  - hc (8-bit) increments.
  - When hc==R0: hc<=0 and end-of-line processing runs.
  - If R0 is lowered below the current hc, hc counts to 255, wraps to 0 and continues with no end-of-line event.
- Vertical, at end-of-line:
  - If ra==R9: ra<=0 and row (7-bit) increments; otherwise ra increments.
  - When row==R4 and ra==R9, adjust mode is entered if R5!=0; otherwise frame end.
  - Adjust mode counts R5 extra scanlines, with ra continuing from 0 and no row increment, then frame end.
  - Frame end: row<=0, ra<=0.
  - row wraps modulo 128.
- Addressing:
  - Frame end loads lineStart and ma with {R12,R13}.
  - On each cce, ma <= ma+1, modulo 2^MA_W.
  - End-of-line with ra==R9 (row end): lineStart <= lineStart+R1 and ma <= new lineStart.
  - Other end-of-line: ma <= lineStart.
- Display enable: de = (hc < R1) && (row < R6) && !adjust, registered on cce. R1=0 or R6=0 gives de permanently 0.
- hSync:
  - Asserted on the cce where hc==R2.
  - Held for R3[3:0] characters via a 4-bit down-counter.
  - Width 0 means no pulse.
  - A pulse crossing end-of-line continues across it.
- vSync:
  - Asserted at the start of scanline ra==0 of row==R7.
  - Held for R3[7:4] scanlines; 0 means 16.
  - A retrigger during an active pulse is ignored.
- Cursor: cursor = de && ma=={R14,R15} && curstart <= ra <= curend. Blink modes are not implemented.
- Output timing:
  - All timing outputs are registered and update only on cce edges.
  - Latency is one cce from counter state to output.

Decomposition:
- Package crtc_pkg holds:
  - register index constants R_HTOTAL..R_CURLO (0..15);
  - localparam VSYNC_ZERO_LINES=16.
- Sub-module crtc_regs holds the address latch, register file and dout mux.
- Counters and sync logic stay in crtc.

Test Plan:
- Program R0=9 R1=6 R2=7 R3=0x22 R4=3 R5=1 R6=2 R7=3 R9=1 R12=0 R13=0x10, then run cce every cycle.
  - Required: line = 10 cce; de high for hc 0..5 only in rows 0-1; hSync high for exactly 2 cce starting at hc 7.
- Same setup, check addressing and frame length.
  - Required: ma at line start is 0x010 for row 0 (both scanlines) and 0x016 for row 1; frame = 9 scanlines = 90 cce; vSync high for 2 scanlines starting row 3 ra 0.
- Set R3=0x02, then rerun the frame.
  - Required: vSync lasts 16 scanlines, spanning the frame wrap.
- Set R14=0x00 R15=0x12 R10=1 R11=1, then read back R14/R15 with rs=1.
  - Required: dout = 0x00 and 0x12; cursor pulses for 1 cce at ma=0x012, ra=1 only.
- Mid-line, with hc=8, write R0=4.
  - Required: hc runs to 255, wraps to 0, then lines are 5 cce; assert reset mid-frame and all outputs go to 0 immediately.
- Write addr=20, data=0xFF.
  - Required: no register changes; dout stays 0.
